logic_unit_sweep: RTL and testbench
===================================

Name: logic_unit_sweep

Overview:
- Parametrised successor to the team's fixed single-function NOR-gate exercises.
- Registered WIDTH-bit bitwise logic unit with eight selectable functions, including AND-NOT (a & ~b).
- Valid/ready handshake on input and output.
- Built-in sweep mode walks every operand combination for one function and folds the results into a signature, so a bench can check an entire truth table with one compare.

Parameters:
- WIDTH, 4: operand/result width in bits; 1..8 when sweep is used.
- CNT_W, 2*WIDTH: sweep counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  function select for the normal path
- out_valid  output  1  s holds a result
- out_ready  input  1  consumer takes the result
- s  output  WIDTH  registered result
- sweep_start  input  1  request a sweep
- sweep_op  input  3  function used during the sweep
- sweep_busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse when the sweep finishes
- signature  output  WIDTH  sweep signature; held until the next sweep_start
- sweep_count  output  CNT_W  current sweep index

Behaviour:
- Reset values: all outputs 0. Sweep FSM state IDLE, counter 0.
- Reset is synchronous and has priority over every other event, including mid-sweep: the sweep aborts and no sweep_done is issued.
- Function encoding, applied bitwise:
  - 0 AND, 1 OR, 2 NAND, 3 NOR
  - 4 XOR, 5 XNOR, 6 ANDN (a & ~b), 7 ORN (a | ~b)
- Normal path:
  - in_ready = (state==IDLE) & ~sweep_start & (~out_valid | out_ready).
  - Transfer happens when in_valid & in_ready. Next edge: s <= f(op,a,b), out_valid <= 1. Latency is 1 cycle.
  - When out_valid & out_ready and no new transfer: out_valid <= 0; s keeps its last value.
  - When a consume and a transfer occur in the same cycle: s is replaced and out_valid stays 1, giving full throughput.
  - When out_valid & ~out_ready: s and out_valid are held stable and in_ready = 0.
- Sweep FSM, states IDLE, SWEEP, DONE:
  - IDLE -> SWEEP on sweep_start. Same edge: signature <= 0, counter <= 0, latch sweep_op.
  - sweep_start is ignored outside IDLE. If it coincides with in_valid, the sweep wins and no operand transfer occurs.
  - SWEEP, each cycle:
    - operands {sa, sb} = counter, with sa = counter[CNT_W-1:WIDTH] and sb = counter[WIDTH-1:0];
    - r = f(latched op, sa, sb);
    - signature <= rotl1(signature) ^ r (rotate left by one, then XOR);
    - counter increments.
  - SWEEP covers exactly 2^CNT_W cycles. The last cycle is counter = all ones. The counter wraps to 0 and the FSM goes to DONE.
  - DONE: sweep_done = 1 for exactly one cycle, then IDLE.
  - sweep_busy = 1 in SWEEP only. sweep_count mirrors the counter.
- Interaction between the paths:
  - An already pending normal result can still drain through out_ready during a sweep.
  - No new operands are accepted until the FSM returns to IDLE.
- Width rules: all functions are bitwise with no carry. The counter is exactly CNT_W bits, so wrap-around is natural.

Decomposition:
- Shared package logic_unit_pkg holds:
  - the op encodings as named 3-bit constants;
  - the sweep state encoding;
  - the pure function logic_f(op, a, b) used by both paths and by the bench reference model.
- Natural sub-module logic_fn: combinational WIDTH-bit function slice. Instantiate it twice, once for the normal path and once for the sweep path, so both can be active in the same cycle.

Test Plan:
1. Reset: hold reset 2 cycles, then release -> all outputs 0, in_ready = 1. Asserting reset mid-sweep at sweep_count = 5 -> next cycle sweep_busy = 0, signature = 0, no sweep_done pulse.
2. Directed ops, WIDTH=4, a = 4'b1100, b = 4'b1010, out_ready = 1:
   - op 6 -> s = 4'b0100
   - op 3 -> s = 4'b0001
   - op 4 -> s = 4'b0110
   - op 7 -> s = 4'b1101
   - Each result appears 1 cycle after the transfer.
3. Backpressure: out_ready = 0 with a result pending -> in_ready = 0 and s stable for 3 cycles. Raise out_ready with a new in_valid in the same cycle -> back-to-back transfer, out_valid never drops.
4. Sweep at WIDTH=1, sweep_op = 6:
   - r sequence across {a,b} = 00, 01, 10, 11 is 0, 0, 1, 0;
   - final signature = 1'b1;
   - sweep_busy high 4 cycles, then a single-cycle sweep_done.
5. Sweep at WIDTH=4, sweep_op = 0 -> 256 busy cycles. Signature matches the bench model built on logic_f. A sweep_start raised while busy is ignored.
6. Priority: sweep_start and in_valid asserted in the same IDLE cycle -> sweep begins, in_ready = 0, and no normal result is produced.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sweepable logic unit: op encodings, sweep states
// and the per-bit logic function used by both datapaths.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_ORN  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;

  // Every function is bitwise, so a single-bit kernel covers any width.
  function automatic logic logic_f(input logic [2:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_sweep_fn.sv
// Combinational WIDTH-bit logic slice: one logic_f kernel per bit lane.
module logic_fn
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign y[i] = logic_f(op, a[i], b[i]);
  end

endmodule

// File: rtl/logic_unit_sweep.sv
// Registered bitwise logic unit with valid/ready handshake and a self-sweep
// mode that folds a whole truth table into a rotate-XOR signature.
module logic_unit_sweep
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  input  logic             sweep_start,
  input  logic [2:0]       sweep_op,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] sweep_count
);

  sweep_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] norm_r, swp_r, sig_rot;
  logic             xfer;

  logic_fn #(.WIDTH(WIDTH)) u_fn_norm (.op(op),   .a(a),                   .b(b),              .y(norm_r));
  logic_fn #(.WIDTH(WIDTH)) u_fn_swp  (.op(op_q), .a(cnt[CNT_W-1:WIDTH]), .b(cnt[WIDTH-1:0]), .y(swp_r));

  if (WIDTH == 1) begin : g_rot1
    assign sig_rot = signature;
  end else begin : g_rotn
    assign sig_rot = {signature[WIDTH-2:0], signature[WIDTH-1]};
  end

  // A sweep request in IDLE blocks the same-cycle operand transfer.
  assign in_ready    = (state == ST_IDLE) & ~sweep_start & (~out_valid | out_ready);
  assign xfer        = in_valid & in_ready;
  assign sweep_count = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      s         <= norm_r;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= 3'd0;
      signature  <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sweep_start) begin
            state      <= ST_SWEEP;
            cnt        <= '0;
            op_q       <= sweep_op;
            signature  <= '0;
            sweep_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          signature <= sig_rot ^ swp_r;
          cnt       <= cnt + 1'b1;
          if (&cnt) begin
            state      <= ST_DONE;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          sweep_done <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          sweep_busy <= 1'b0;
          sweep_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_sweep.sv
// Directed bench for logic_unit_sweep: a WIDTH=4 unit for the datapath, sweep
// and reset cases, and a WIDTH=1 unit for the hand-traced sweep.
module tb_logic_unit_sweep;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // WIDTH=4 instance
  logic       reset, in_valid, out_ready, sweep_start;
  logic [3:0] a, b;
  logic [2:0] op, sweep_op;
  logic       in_ready, out_valid, sweep_busy, sweep_done;
  logic [3:0] s, signature;
  logic [7:0] sweep_count;

  // WIDTH=1 instance
  logic       in_valid1, out_ready1, sweep_start1;
  logic [0:0] a1, b1;
  logic [2:0] op1, sweep_op1;
  logic       in_ready1, out_valid1, sweep_busy1, sweep_done1;
  logic [0:0] s1, signature1;
  logic [1:0] sweep_count1;

  logic_unit_sweep #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .sweep_start(sweep_start), .sweep_op(sweep_op), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .signature(signature), .sweep_count(sweep_count)
  );

  logic_unit_sweep #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1), .s(s1),
    .sweep_start(sweep_start1), .sweep_op(sweep_op1), .sweep_busy(sweep_busy1),
    .sweep_done(sweep_done1), .signature(signature1), .sweep_count(sweep_count1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] d_op  [4] = '{3'd6, 3'd3, 3'd4, 3'd7};
  logic [3:0] d_exp [4] = '{4'b0100, 4'b0001, 4'b0110, 4'b1101};
  logic       sig1_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [3:0] model;
    logic [3:0] sa, sb, r;
    int busy_n, k;
    bit done_seen, done_twice;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b0;
    a = '0; b = '0; op = '0; sweep_op = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; sweep_start1 = 1'b0;
    a1 = '0; b1 = '0; op1 = '0; sweep_op1 = '0;

    // reset
    step(); step();
    chk("rst_s", s, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_sig", signature, 0);
    chk("rst_count", sweep_count, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // directed ops, a=1100 b=1010
    a = 4'b1100; b = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      op = d_op[i][2:0]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("op%0d_s", d_op[i]), s, d_exp[i]);
      chk($sformatf("op%0d_vld", d_op[i]), out_valid, 1);
      step();
      chk($sformatf("op%0d_drain", d_op[i]), out_valid, 0);
      chk($sformatf("op%0d_hold", d_op[i]), s, d_exp[i]);
    end

    // backpressure: AND pending (1000), OR (1110) waiting
    out_ready = 1'b0; op = OP_AND; in_valid = 1'b1;
    step();
    op = OP_OR;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_s", s, 4'b1000);
      chk("bp_vld", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b_s", s, 4'b1110);
    chk("b2b_vld", out_valid, 1);
    step();
    chk("b2b_drain", out_valid, 0);

    // priority: sweep_start with in_valid, then full AND sweep
    op = OP_XOR; in_valid = 1'b1; sweep_start = 1'b1; sweep_op = OP_AND;
    #1;
    chk("prio_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0; sweep_start = 1'b0;
    chk("prio_busy", sweep_busy, 1);
    chk("prio_no_result", out_valid, 0);
    chk("prio_s_kept", s, 4'b1110);

    model = '0;
    for (int i = 0; i < 256; i++) begin
      sa = 4'(i >> 4); sb = 4'(i);
      for (int j = 0; j < 4; j++) r[j] = logic_f(OP_AND, sa[j], sb[j]);
      model = {model[2:0], model[3]} ^ r;
    end

    busy_n = 0; done_seen = 0;
    for (k = 0; k < 400; k++) begin
      if (sweep_busy) begin
        busy_n++;
        if (busy_n == 11) chk("sw_count_mirror", sweep_count, 10);
        if (busy_n == 20) begin
          chk("sw_busy_in_ready", in_ready, 0);
          sweep_start = 1'b1; sweep_op = OP_NOR;
        end
        if (busy_n == 21) sweep_start = 1'b0;
      end
      if (sweep_done) begin
        done_seen = 1;
        break;
      end
      step();
    end
    sweep_start = 1'b0;
    chk("sw_done_seen", done_seen, 1);
    chk("sw_busy_cycles", busy_n, 256);
    chk("sw_sig", signature, model);
    step();
    chk("sw_done_pulse", sweep_done, 0);
    chk("sw_sig_held", signature, model);
    chk("sw_idle_ready", in_ready, 1);

    // reset mid-sweep at sweep_count 5
    sweep_start = 1'b1; sweep_op = OP_XOR;
    step();
    sweep_start = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (sweep_count == 5) break;
      step();
    end
    chk("mid_count5", sweep_count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_busy", sweep_busy, 0);
    chk("mid_sig", signature, 0);
    chk("mid_count", sweep_count, 0);
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (sweep_done) done_seen = 1;
      step();
    end
    chk("mid_no_done", done_seen, 0);

    // WIDTH=1 sweep, ANDN: r = 0,0,1,0
    sweep_start1 = 1'b1; sweep_op1 = OP_ANDN;
    step();
    sweep_start1 = 1'b0;
    busy_n = 0; done_seen = 0; done_twice = 0;
    for (k = 0; k < 20; k++) begin
      if (sweep_busy1) begin
        if (busy_n < 4) chk($sformatf("w1_sig_at%0d", busy_n), signature1, sig1_exp[busy_n]);
        busy_n++;
      end
      if (sweep_done1) begin
        if (done_seen) done_twice = 1;
        done_seen = 1;
      end
      if (done_seen && !sweep_done1) break;
      step();
    end
    chk("w1_busy_cycles", busy_n, 4);
    chk("w1_done_seen", done_seen, 1);
    chk("w1_done_single", done_twice, 0);
    chk("w1_sig", signature1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
